instr_mem_responder: RTL and testbench

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/instr_mem_pkg.sv | 18 +
 rtl/instr_mem_array.sv | 33 +++
 rtl/instr_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_instr_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory responder.
//   - state_e     : responder FSM states (IDLE, WAIT, RESP)
//   - NopInstr    : RV32I NOP (addi x0, x0, 0), returned for misaligned fetches
//   - DefWaitCycles / DefDepthWords : default parameter values for the top
package instr_mem_pkg;

  localparam int unsigned DefWaitCycles = 2;
  localparam int unsigned DefDepthWords = 256;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: DEPTH_WORDS x 32-bit words, one synchronous write port
// (program loader) and one asynchronous read port (fetch path). No reset, so
// contents survive a responder reset.
//
// Ports:
//   clk_i    - clock, write on rising edge
//   we_i     - write enable
//   waddr_i  - write word index
//   wdata_i  - write data
//   raddr_i  - read word index
//   rdata_o  - read data (combinational from raddr_i)
module instr_mem_array #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [31:0]                    wdata_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: accepts a fetch request when idle, waits
// WAIT_CYCLES cycles, then presents the fetched word with a one-cycle RVALID.
// A loader write port fills the store in any state, including during reset.
//
// Optional feature (macro INSTR_MEM_ALIGN_CHECK_EN): misaligned fetches
// (ADDR[1:0] != 0) return NOP with ERR=1. Without it ADDR[1:0] is ignored and
// ERR is tied low.
//
// Ports:
//   CLK     - clock, rising edge
//   RST     - synchronous active-high reset
//   REQ     - fetch request
//   ADDR    - fetch byte address
//   READY   - high in IDLE, request can be accepted
//   RVALID  - one-cycle pulse, RDATA valid
//   RDATA   - fetched word, held between responses
//   ERR     - misalignment flag, only meaningful with RVALID
//   WR_EN   - loader write strobe
//   WR_ADDR - loader byte address
//   WR_DATA - loader write word
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DefWaitCycles,
  parameter int unsigned DEPTH_WORDS = DefDepthWords
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic [31:0] ADDR,
  output logic        READY,
  output logic        RVALID,
  output logic [31:0] RDATA,
  output logic        ERR,
  input  logic        WR_EN,
  input  logic [31:0] WR_ADDR,
  input  logic [31:0] WR_DATA
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitCnt = 4'(WAIT_CYCLES);

  // Only the byte-offset bits are kept when they are needed for the check.
`ifdef INSTR_MEM_ALIGN_CHECK_EN
  localparam int unsigned LoBit = 0;
`else
  localparam int unsigned LoBit = 2;
`endif

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IdxW+1:LoBit]     addr_q, addr_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [IdxW+1:LoBit]     rd_addr;
  logic [31:0]             mem_rdata;
  logic                    enter_resp;

  // In IDLE the read is steered from the live ADDR so that WAIT_CYCLES=0 can
  // capture on the acceptance edge itself.
  assign rd_addr = (state_q == IDLE) ? ADDR[IdxW+1:LoBit] : addr_q;

  instr_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (WR_EN),
    .waddr_i (WR_ADDR[IdxW+1:2]),
    .wdata_i (WR_DATA),
    .raddr_i (rd_addr[IdxW+1:2]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          addr_d = ADDR[IdxW+1:LoBit];
          cnt_d  = WaitCnt;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef INSTR_MEM_ALIGN_CHECK_EN
  logic misaligned;
  logic err_q, err_d;

  assign misaligned = (rd_addr[1:0] != 2'b00);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (enter_resp) begin
      rdata_d = misaligned ? NopInstr : mem_rdata;
      err_d   = misaligned;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;

  logic unused_addr;
  assign unused_addr = ^ADDR[31:IdxW+2];
`else
  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      rdata_d = mem_rdata;
    end
  end

  assign ERR = 1'b0;

  logic unused_addr;
  assign unused_addr = ^{ADDR[31:IdxW+2], ADDR[1:0]};
`endif

  logic unused_wr_addr;
  assign unused_wr_addr = ^{WR_ADDR[31:IdxW+2], WR_ADDR[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign READY  = (state_q == IDLE);
  assign RVALID = (state_q == RESP);
  assign RDATA  = rdata_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: instance A uses WAIT_CYCLES=2, instance B uses WAIT_CYCLES=0.
module tb_instr_mem_responder;

  localparam int unsigned WaitA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, ready_a, rvalid_a, err_a, wr_en_a;
  logic [31:0] addr_a, rdata_a, wr_addr_a, wr_data_a;
  logic        req_b, ready_b, rvalid_b, err_b, wr_en_b;
  logic [31:0] addr_b, rdata_b, wr_addr_b, wr_data_b;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  instr_mem_responder #(
    .WAIT_CYCLES (WaitA),
    .DEPTH_WORDS (256)
  ) u_dut_a (
    .CLK     (clk),
    .RST     (rst),
    .REQ     (req_a),
    .ADDR    (addr_a),
    .READY   (ready_a),
    .RVALID  (rvalid_a),
    .RDATA   (rdata_a),
    .ERR     (err_a),
    .WR_EN   (wr_en_a),
    .WR_ADDR (wr_addr_a),
    .WR_DATA (wr_data_a)
  );

  instr_mem_responder #(
    .WAIT_CYCLES (0),
    .DEPTH_WORDS (256)
  ) u_dut_b (
    .CLK     (clk),
    .RST     (rst),
    .REQ     (req_b),
    .ADDR    (addr_b),
    .READY   (ready_b),
    .RVALID  (rvalid_b),
    .RDATA   (rdata_b),
    .ERR     (err_b),
    .WR_EN   (wr_en_b),
    .WR_ADDR (wr_addr_b),
    .WR_DATA (wr_data_b)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One fetch on A; optionally a loader write during wait cycle wr_cyc
  // (wr_cyc == WaitA lands on the RDATA capture edge).
  task automatic fetch_a(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int wr_cyc, input logic [31:0] wr_addr,
                         input logic [31:0] wr_data);
    expect_eq({tag, " ready before"}, 32'(ready_a), 32'd1);
    req_a  = 1'b1;
    addr_a = addr;
    tick();
    req_a  = 1'b0;
    for (int k = 1; k <= int'(WaitA); k++) begin
      expect_eq({tag, " wait ready"}, 32'(ready_a), 32'd0);
      expect_eq({tag, " wait rvalid"}, 32'(rvalid_a), 32'd0);
      if (k == wr_cyc) begin
        wr_en_a   = 1'b1;
        wr_addr_a = wr_addr;
        wr_data_a = wr_data;
      end
      tick();
      wr_en_a = 1'b0;
    end
    expect_eq({tag, " resp rvalid"}, 32'(rvalid_a), 32'd1);
    expect_eq({tag, " resp ready"}, 32'(ready_a), 32'd0);
    expect_eq({tag, " resp rdata"}, rdata_a, exp_data);
    expect_eq({tag, " resp err"}, 32'(err_a), 32'(exp_err));
    tick();
    expect_eq({tag, " after rvalid"}, 32'(rvalid_a), 32'd0);
    expect_eq({tag, " after ready"}, 32'(ready_a), 32'd1);
    expect_eq({tag, " after rdata hold"}, rdata_a, exp_data);
    expect_eq({tag, " after err"}, 32'(err_a), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_b;
    logic [31:0] exp_mis_data;
    logic        exp_mis_err;
    exp_b = 32'h0;

    rst = 1'b1;
    req_a = 1'b0; addr_a = 32'h0; wr_en_a = 1'b0; wr_addr_a = 32'h0; wr_data_a = 32'h0;
    req_b = 1'b0; addr_b = 32'h0; wr_en_b = 1'b0; wr_addr_b = 32'h0; wr_data_b = 32'h0;
    tick();

    // Loader writes while reset is held must still land.
    wr_en_a = 1'b1; wr_addr_a = 32'h4; wr_data_a = 32'h0050_0093;
    wr_en_b = 1'b1; wr_addr_b = 32'h0; wr_data_b = 32'h1234_5678;
    tick();
    wr_addr_a = 32'h0; wr_data_a = 32'hAAAA_0000;
    wr_addr_b = 32'h4; wr_data_b = 32'h9ABC_DEF0;
    tick();
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    rst     = 1'b0;

    expect_eq("reset ready", 32'(ready_a), 32'd1);
    expect_eq("reset rvalid", 32'(rvalid_a), 32'd0);
    expect_eq("reset rdata", rdata_a, 32'h0);
    expect_eq("reset err", 32'(err_a), 32'd0);
    expect_eq("reset ready b", 32'(ready_b), 32'd1);

    fetch_a("basic", 32'h4, 32'h0050_0093, 1'b0, -1, 32'h0, 32'h0);
    fetch_a("wrap", 32'h404, 32'h0050_0093, 1'b0, -1, 32'h0, 32'h0);
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    exp_mis_data = 32'h0000_0013;
    exp_mis_err  = 1'b1;
`else
    exp_mis_data = 32'h0050_0093;
    exp_mis_err  = 1'b0;
`endif
    fetch_a("misaligned", 32'h6, exp_mis_data, exp_mis_err, -1, 32'h0, 32'h0);
    fetch_a("word0", 32'h0, 32'hAAAA_0000, 1'b0, -1, 32'h0, 32'h0);

    // REQ held through WAIT/RESP with a different ADDR must not disturb the fetch.
    req_a = 1'b1; addr_a = 32'h0;
    tick();
    addr_a = 32'h4;
    tick();
    tick();
    expect_eq("busy req rvalid", 32'(rvalid_a), 32'd1);
    expect_eq("busy req rdata", rdata_a, 32'hAAAA_0000);
    req_a = 1'b0;
    tick();
    expect_eq("busy req idle ready", 32'(ready_a), 32'd1);
    tick();
    expect_eq("busy req no extra rvalid", 32'(rvalid_a), 32'd0);
    expect_eq("busy req still ready", 32'(ready_a), 32'd1);

    // Write to the fetched word on the capture edge: old data now, new data next time.
    fetch_a("rdw old", 32'h4, 32'h0050_0093, 1'b0, int'(WaitA), 32'h4, 32'hDEAD_BEEF);
    fetch_a("rdw new", 32'h4, 32'hDEAD_BEEF, 1'b0, -1, 32'h0, 32'h0);

    // Reset during WAIT drops the fetch.
    req_a = 1'b1; addr_a = 32'h4;
    tick();
    req_a = 1'b0;
    expect_eq("rst wait ready", 32'(ready_a), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_eq("rst ready", 32'(ready_a), 32'd1);
    expect_eq("rst rvalid", 32'(rvalid_a), 32'd0);
    expect_eq("rst rdata", rdata_a, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_eq("rst no rvalid", 32'(rvalid_a), 32'd0);
      expect_eq("rst stays ready", 32'(ready_a), 32'd1);
    end
    fetch_a("mem kept", 32'h4, 32'hDEAD_BEEF, 1'b0, -1, 32'h0, 32'h0);

    // WAIT_CYCLES=0 with REQ held: accept / respond alternates every cycle.
    req_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        expect_eq("b0 idle ready", 32'(ready_b), 32'd1);
        expect_eq("b0 idle rvalid", 32'(rvalid_b), 32'd0);
        addr_b = ((k / 2) % 2 == 1) ? 32'h4 : 32'h0;
        exp_b  = ((k / 2) % 2 == 1) ? 32'h9ABC_DEF0 : 32'h1234_5678;
      end else begin
        expect_eq("b0 resp rvalid", 32'(rvalid_b), 32'd1);
        expect_eq("b0 resp ready", 32'(ready_b), 32'd0);
        expect_eq("b0 resp rdata", rdata_b, exp_b);
        expect_eq("b0 resp err", 32'(err_b), 32'd0);
        addr_b = 32'h8;
      end
      tick();
    end
    req_b = 1'b0;
    tick();
    expect_eq("b0 final ready", 32'(ready_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
